// File: rtl/s_proc_pkg.sv
// Shared constants for the Simple CPU V1 control path: opcodes, sequencer
// state encoding, ALU select codes and address-mux selects.
package s_proc_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_DECODE   = 3'd2;
    localparam logic [2:0] ST_EXEC_MEM = 3'd3;
    localparam logic [2:0] ST_HALT     = 3'd4;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_AND  = 2'b11;

    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_OPR = 1'b1;

endpackage

// File: rtl/ctrl_dec.sv
// Combinational opcode classifier for the instruction sequencer.
module ctrl_dec
    import s_proc_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] ir_op,
    output logic            is_mem,
    output logic            is_store,
    output logic            is_jmp,
    output logic            is_jz,
    output logic            is_halt,
    output logic            is_illegal,
    output logic [1:0]      alu_op
);

    // Classify the opcode; anything not listed is illegal.
    always_comb begin
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_jmp     = 1'b0;
        is_jz      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        alu_op     = ALU_PASS;
        case (ir_op)
            OP_W'(OP_NOP):   is_mem = 1'b0;
            OP_W'(OP_LOAD):  is_mem = 1'b1;
            OP_W'(OP_STORE): begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_W'(OP_ADD): begin
                is_mem = 1'b1;
                alu_op = ALU_ADD;
            end
            OP_W'(OP_SUB): begin
                is_mem = 1'b1;
                alu_op = ALU_SUB;
            end
            OP_W'(OP_AND): begin
                is_mem = 1'b1;
                alu_op = ALU_AND;
            end
            OP_W'(OP_JMP):   is_jmp  = 1'b1;
            OP_W'(OP_JZ):    is_jz   = 1'b1;
            OP_W'(OP_HALT):  is_halt = 1'b1;
            default:         is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Instruction-sequencing FSM and retired-instruction counter for Simple CPU V1.
// Build option CTRL_SEQ_ILLEGAL_TRAP_EN: illegal opcodes halt and set a sticky flag.
module ctrl_seq
    import s_proc_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             mem_ack,
    input  logic [OP_W-1:0]  ir_op,
    input  logic             zero,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             en_ir,
    output logic             en_pc,
    output logic             ld_pc,
    output logic             en_acc,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             retire_s;
    logic             is_mem_s;
    logic             is_store_s;
    logic             is_jmp_s;
    logic             is_jz_s;
    logic             is_halt_s;
    logic             is_illegal_s;
    logic [1:0]       dec_alu_s;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    logic             trap_s;
    logic             illegal_r;
`endif

    ctrl_dec #(
        .OP_W(OP_W)
    ) u_dec (
        .ir_op      (ir_op),
        .is_mem     (is_mem_s),
        .is_store   (is_store_s),
        .is_jmp     (is_jmp_s),
        .is_jz      (is_jz_s),
        .is_halt    (is_halt_s),
        .is_illegal (is_illegal_s),
        .alu_op     (dec_alu_s)
    );

    // Next-state and Mealy output decode; IR stays stable through EXEC_MEM.
    always_comb begin
        state_nxt_s = state_r;
        retire_s    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = ADDR_PC;
        en_ir       = 1'b0;
        en_pc       = 1'b0;
        ld_pc       = 1'b0;
        en_acc      = 1'b0;
        alu_op      = ALU_PASS;
        halted      = 1'b0;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
        trap_s      = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_PC;
                if (mem_ack) begin
                    en_ir       = 1'b1;
                    en_pc       = 1'b1;
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (is_mem_s) begin
                    state_nxt_s = ST_EXEC_MEM;
                end else if (is_halt_s) begin
                    retire_s    = 1'b1;
                    state_nxt_s = ST_HALT;
                end else if (is_illegal_s) begin
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
                    trap_s      = 1'b1;
                    state_nxt_s = ST_HALT;
`else
                    retire_s    = 1'b1;
                    state_nxt_s = ST_FETCH;
`endif
                end else begin
                    ld_pc       = is_jmp_s | (is_jz_s & zero);
                    retire_s    = 1'b1;
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_EXEC_MEM: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_OPR;
                mem_we   = is_store_s;
                alu_op   = dec_alu_s;
                if (mem_ack) begin
                    en_acc      = ~is_store_s;
                    retire_s    = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_EXEC_MEM;
                end
            end
            ST_HALT: begin
                halted      = 1'b1;
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and trap-flag registers; clr aborts everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
            illegal_r <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            if (retire_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
            illegal_r <= illegal_r | trap_s;
`endif
        end
    end

    assign instr_cnt = cnt_r;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    assign illegal   = illegal_r;
`endif

endmodule
